grap_io_seq: RTL



---
 rtl/grap_io_pkg.sv | 30 +++
 rtl/grap_io_seq_if.sv | 20 ++
 rtl/grap_io_edge.sv | 32 +++
 rtl/grap_io_seq.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/grap_io_pkg.sv
// Shared types and constants for the graphics-controller I/O access sequencer.
package grap_io_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        RDREQ = 3'd2,
        RDCAP = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [15:0] GR_IDX_ADDR = 16'h03CE;
    localparam logic [15:0] GR_DAT_ADDR = 16'h03CF;

    localparam int unsigned WAIT_CNT_W = 4;
    localparam int unsigned IDX_W      = 8;

    // Index is backed by a real register-file entry
    function automatic logic idx_impl(input logic [IDX_W-1:0] idx, input logic [IDX_W-1:0] max_idx);
        return idx <= max_idx;
    endfunction

    // Post-increment with wrap at (or beyond) the top implemented index
    function automatic logic [IDX_W-1:0] idx_wrap_inc(input logic [IDX_W-1:0] idx,
                                                       input logic [IDX_W-1:0] max_idx);
        return (idx >= max_idx) ? IDX_W'(0) : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/grap_io_seq_if.sv
// Host I/O bus as seen by the sequencer: strobes, address, data and ready.
interface grap_io_seq_if;
    logic        h_iord;
    logic        h_iowr;
    logic        h_io_16;
    logic [15:0] h_io_addr;
    logic [15:0] h_io_dbus;
    logic [15:0] h_io_rdata;
    logic        h_ready_n;

    modport master (
        output h_iord, h_iowr, h_io_16, h_io_addr, h_io_dbus,
        input  h_io_rdata, h_ready_n
    );

    modport slave (
        input  h_iord, h_iowr, h_io_16, h_io_addr, h_io_dbus,
        output h_io_rdata, h_ready_n
    );
endinterface

// File: rtl/grap_io_edge.sv
// Host strobe sampling: level, qualified rising edge (rd+wr together is rejected) and falling edge.
module grap_io_edge (
    input  logic h_hclk,
    input  logic h_reset_n,
    input  logic iord,
    input  logic iowr,
    output logic str_lvl,
    output logic rise_c,
    output logic fall_c
);

    logic str_q;
    logic str_d;
    logic err_q;

    always_ff @(posedge h_hclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            str_q <= 1'b0;
            str_d <= 1'b0;
            err_q <= 1'b0;
        end else begin
            str_q <= iord | iowr;
            str_d <= str_q;
            err_q <= iord & iowr;
        end
    end

    assign str_lvl = str_q;
    assign rise_c  = str_q & ~str_d & ~err_q;
    assign fall_c  = str_d & ~str_q;

endmodule

// File: rtl/grap_io_seq.sv
// Host I/O sequencer for the graphics register file at 3CE/3CF.
// Optional index post-increment on data accesses: define GRAP_IDX_AUTOINC_EN.
module grap_io_seq
    import grap_io_pkg::*;
#(
    parameter int unsigned WAIT_CYC = 1,
    parameter int unsigned MAX_IDX  = 8
) (
    input  logic             h_hclk,
    input  logic             h_reset_n,
    grap_io_seq_if.slave     host,
    input  logic [IDX_W-1:0] rf_rdata,
    output logic [IDX_W-1:0] rf_idx,
    output logic             rf_wr,
    output logic             rf_rd,
    output logic [IDX_W-1:0] rf_wdata,
    output logic             seq_busy
);

`ifdef GRAP_IDX_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD    = WAIT_CNT_W'(WAIT_CYC);
    localparam logic [IDX_W-1:0]      MAX_IDX_V    = IDX_W'(MAX_IDX);
    localparam state_t                WAIT_OR_DONE = (WAIT_CYC == 0) ? DONE : WAIT;

    logic str_lvl;
    logic rise_c;
    logic fall_c;

    state_t state;
    state_t state_nx;

    logic [WAIT_CNT_W-1:0] cnt,      cnt_nx;
    logic [IDX_W-1:0]      idx_q,    idx_nx;
    logic [IDX_W-1:0]      wdata_q,  wdata_nx;
    logic [15:0]           rdata_q,  rdata_nx;
    logic                  dat_q,    dat_nx;
    logic                  wr_q,     wr_nx;
    logic                  rd_q,     rd_nx;
    logic                  rdy_n_q,  rdy_n_nx;
    logic                  busy_q,   busy_nx;

    logic hit_c;
    logic is_dat_c;

    grap_io_edge u_edge (
        .h_hclk    (h_hclk),
        .h_reset_n (h_reset_n),
        .iord      (host.h_iord),
        .iowr      (host.h_iowr),
        .str_lvl   (str_lvl),
        .rise_c    (rise_c),
        .fall_c    (fall_c)
    );

    assign is_dat_c = (host.h_io_addr == GR_DAT_ADDR);
    assign hit_c    = is_dat_c || (host.h_io_addr == GR_IDX_ADDR);

    // State register
    always_ff @(posedge h_hclk or negedge h_reset_n) begin
        if (!h_reset_n) state <= IDLE;
        else            state <= state_nx;
    end

    // Next state; a dropped strobe aborts any access not yet in DONE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (rise_c && hit_c) begin
                    if (host.h_iowr) state_nx = (is_dat_c || host.h_io_16) ? DATA : WAIT_OR_DONE;
                    else             state_nx = is_dat_c ? RDREQ : WAIT_OR_DONE;
                end
            end
            DATA:    state_nx = WAIT_OR_DONE;
            RDREQ:   state_nx = RDCAP;
            RDCAP:   state_nx = WAIT_OR_DONE;
            WAIT:    if (cnt <= WAIT_CNT_W'(1)) state_nx = DONE;
            DONE:    if (fall_c) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (state != IDLE && state != DONE && !str_lvl) state_nx = IDLE;
    end

    // Datapath and registered-output next values, aligned with the state being entered
    always_comb begin
        idx_nx   = idx_q;
        wdata_nx = wdata_q;
        rdata_nx = rdata_q;
        cnt_nx   = cnt;
        dat_nx   = dat_q;

        if (state == IDLE && state_nx != IDLE) begin
            dat_nx = is_dat_c;
            if (host.h_iowr) begin
                if (is_dat_c) begin
                    wdata_nx = host.h_io_dbus[15:8];
                end else begin
                    idx_nx = host.h_io_dbus[7:0];
                    if (host.h_io_16) wdata_nx = host.h_io_dbus[15:8];
                end
            end else if (!is_dat_c) begin
                rdata_nx[7:0] = idx_q;
            end
        end

        if (state == RDCAP)
            rdata_nx[15:8] = idx_impl(idx_q, MAX_IDX_V) ? rf_rdata : 8'h00;

        if (state_nx == WAIT && state != WAIT) cnt_nx = WAIT_LOAD;
        else if (state == WAIT)                cnt_nx = cnt - WAIT_CNT_W'(1);

        if (AUTOINC && dat_q && state != IDLE && state != DONE && state_nx == DONE)
            idx_nx = idx_wrap_inc(idx_q, MAX_IDX_V);

        wr_nx    = (state_nx == DATA)  && idx_impl(idx_nx, MAX_IDX_V);
        rd_nx    = (state_nx == RDREQ) && idx_impl(idx_nx, MAX_IDX_V);
        rdy_n_nx = (state_nx != DONE);
        busy_nx  = (state_nx != IDLE);
    end

    always_ff @(posedge h_hclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            dat_q   <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            rdy_n_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            idx_q   <= idx_nx;
            wdata_q <= wdata_nx;
            rdata_q <= rdata_nx;
            dat_q   <= dat_nx;
            wr_q    <= wr_nx;
            rd_q    <= rd_nx;
            rdy_n_q <= rdy_n_nx;
            busy_q  <= busy_nx;
        end
    end

    assign rf_idx          = idx_q;
    assign rf_wdata        = wdata_q;
    assign rf_wr           = wr_q;
    assign rf_rd           = rd_q;
    assign seq_busy        = busy_q;
    assign host.h_io_rdata = rdata_q;
    assign host.h_ready_n  = rdy_n_q;

endmodule
